// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - register map constants and address decode helper for the multi-channel PWM
package pwm_pkg;

  localparam int ADDR_W = 7;

  localparam logic [ADDR_W-1:0] ADDR_ENABLE    = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_PRESC     = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_POLARITY  = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_DUTY_BASE = 7'h10;

  function automatic logic addr_mapped(input logic [ADDR_W-1:0] addr, input int num_ch);
    return (addr == ADDR_ENABLE) || (addr == ADDR_PRESC) || (addr == ADDR_POLARITY) ||
           ((int'(addr) >= int'(ADDR_DUTY_BASE)) && (int'(addr) < int'(ADDR_DUTY_BASE) + num_ch));
  endfunction

endpackage

// File: rtl/pwm_multi_channel_if.sv
// rtl/pwm_multi_channel_if.sv - register write bus between a host and the PWM block
interface pwm_multi_channel_if #(
  parameter int DUTY_W = 8
);
  import pwm_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DUTY_W-1:0] wr_data;
  logic              wr_err;

  modport master (output wr_en, wr_addr, wr_data, input wr_err);
  modport slave  (input wr_en, wr_addr, wr_data, output wr_err);

endinterface

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: duty shadow/active pair, compare and output register
module pwm_channel #(
  parameter int DUTY_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shadow_we,
  input  logic [DUTY_W-1:0] shadow_wdata,
  input  logic              load,
  input  logic [DUTY_W-1:0] period_cnt,
  input  logic              enable,
  input  logic              polarity,
  output logic              pwm_out
);

  logic [DUTY_W-1:0] shadow_q, shadow_d;
  logic [DUTY_W-1:0] active_q, active_d;
  logic              pwm_q, pwm_d;
  logic              raw;

  // load takes shadow_q, so a shadow write coinciding with the wrap waits one more period
  always_comb begin
    shadow_d = shadow_we ? shadow_wdata : shadow_q;
    active_d = load ? shadow_q : active_q;
    raw      = (&active_d) || (period_cnt < active_d);
    pwm_d    = enable ? (raw ^ polarity) : polarity;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// rtl/pwm_multi_channel.sv - multi-channel PWM: register decode, prescaler, period counter
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int DUTY_W  = 8,
  parameter int PRESC_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  pwm_multi_channel_if.slave  bus,
  output logic [NUM_CH-1:0]   pwm_out,
  output logic                period_start
);

  logic [NUM_CH-1:0]  enable_q, enable_d;
  logic [NUM_CH-1:0]  polarity_q, polarity_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [DUTY_W-1:0]  period_cnt_q, period_cnt_d;
  logic               period_start_q, period_start_d;
  logic               wr_err_q, wr_err_d;
  logic               tick, wrap;

  always_comb begin
    enable_d       = enable_q;
    polarity_d     = polarity_q;
    presc_d        = presc_q;
    tick           = (presc_cnt_q == presc_q);
    presc_cnt_d    = tick ? '0 : presc_cnt_q + PRESC_W'(1);
    period_cnt_d   = tick ? period_cnt_q + DUTY_W'(1) : period_cnt_q;
    wrap           = tick && (&period_cnt_q);
    period_start_d = wrap;
    wr_err_d       = bus.wr_en && !addr_mapped(bus.wr_addr, NUM_CH);
    if (bus.wr_en) begin
      case (bus.wr_addr)
        ADDR_ENABLE:   enable_d = bus.wr_data[NUM_CH-1:0];
        ADDR_PRESC: begin
          presc_d     = bus.wr_data[PRESC_W-1:0];
          presc_cnt_d = '0;
        end
        ADDR_POLARITY: polarity_d = bus.wr_data[NUM_CH-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q       <= '0;
      polarity_q     <= '0;
      presc_q        <= '0;
      presc_cnt_q    <= '0;
      period_cnt_q   <= '0;
      period_start_q <= 1'b0;
      wr_err_q       <= 1'b0;
    end else begin
      enable_q       <= enable_d;
      polarity_q     <= polarity_d;
      presc_q        <= presc_d;
      presc_cnt_q    <= presc_cnt_d;
      period_cnt_q   <= period_cnt_d;
      period_start_q <= period_start_d;
      wr_err_q       <= wr_err_d;
    end
  end

  // channels register next-state values so pwm_out lines up with period_start and register writes
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(.DUTY_W(DUTY_W)) u_ch (
      .clk          (clk),
      .rst          (rst),
      .shadow_we    (bus.wr_en && (bus.wr_addr == ADDR_DUTY_BASE + ADDR_W'(i))),
      .shadow_wdata (bus.wr_data),
      .load         (wrap),
      .period_cnt   (period_cnt_d),
      .enable       (enable_d[i]),
      .polarity     (polarity_d[i]),
      .pwm_out      (pwm_out[i])
    );
  end

  assign period_start = period_start_q;
  assign bus.wr_err   = wr_err_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb/tb_pwm_multi_channel.sv - scoreboard bench for pwm_multi_channel
module tb_pwm_multi_channel;

  logic       clk;
  logic       rst;
  logic [7:0] pwm_out;
  logic       period_start;

  pwm_multi_channel_if #(.DUTY_W(8)) bus ();

  pwm_multi_channel #(.NUM_CH(8), .DUTY_W(8), .PRESC_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic sb_push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", obs, -1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic wr(input logic [6:0] addr, input logic [7:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_ps(input int budget, output int ok);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < budget);
    ok = int'(period_start);
  endtask

  // starts on a period_start cycle, ends on the next one; optional write driven at cycle wr_at
  task automatic measure(input int wr_at, input logic [6:0] addr, input logic [7:0] data,
                         output int len, output int hi0, output int hi1, output int first0);
    len    = 0;
    hi0    = 0;
    hi1    = 0;
    first0 = int'(pwm_out[0]);
    do begin
      hi0 += int'(pwm_out[0]);
      hi1 += int'(pwm_out[1]);
      bus.wr_en   = (len == wr_at);
      bus.wr_addr = addr;
      bus.wr_data = data;
      @(negedge clk);
      len++;
    end while (!period_start && len < 5000);
    bus.wr_en = 1'b0;
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ok, len, hi0, hi1, first0, n, hi;
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    wr(7'h00, 8'hFF);
    wr(7'h02, 8'h5A);
    wr(7'h10, 8'h80);
    wr(7'h01, 8'h02);

    rst = 1'b1;
    sb_push("rst_pwm_c1", 0);
    sb_push("rst_pwm_c2", 0);
    sb_push("rst_pwm_c3", 0);
    sb_push("rst_wr_err", 0);
    sb_push("rst_period_start", 0);
    @(negedge clk);
    sb_pop(int'(pwm_out));
    wr(7'h02, 8'hFF);
    sb_pop(int'(pwm_out));
    wr(7'h05, 8'hFF);
    sb_pop(int'(pwm_out));
    sb_pop(int'(bus.wr_err));
    sb_pop(int'(period_start));
    rst = 1'b0;

    sb_push("post_rst_first_wrap", 256);
    sb_push("post_rst_pwm_high", 0);
    n  = 0;
    hi = 0;
    do begin
      @(negedge clk);
      n++;
      hi += int'(|pwm_out);
    end while (!period_start && n < 3000);
    sb_pop(n);
    sb_pop(hi);

    wr(7'h00, 8'h01);
    wr(7'h10, 8'h40);
    sb_push("basic_ps_seen", 1);
    sb_push("basic_len", 256);
    sb_push("basic_hi0", 64);
    sb_push("basic_first0", 1);
    wait_ps(600, ok);
    sb_pop(ok);
    measure(-1, 7'h00, 8'h00, len, hi0, hi1, first0);
    sb_pop(len);
    sb_pop(hi0);
    sb_pop(first0);

    sb_push("glitch_cur_hi0", 64);
    sb_push("glitch_next_hi0", 128);
    sb_push("wrap_write_cur_hi0", 128);
    sb_push("wrap_write_lost_hi0", 128);
    sb_push("wrap_write_late_hi0", 32);
    measure(100, 7'h10, 8'h80, len, hi0, hi1, first0);
    sb_pop(hi0);
    measure(-1, 7'h00, 8'h00, len, hi0, hi1, first0);
    sb_pop(hi0);
    measure(255, 7'h10, 8'h20, len, hi0, hi1, first0);
    sb_pop(hi0);
    measure(-1, 7'h00, 8'h00, len, hi0, hi1, first0);
    sb_pop(hi0);
    measure(-1, 7'h00, 8'h00, len, hi0, hi1, first0);
    sb_pop(hi0);

    wr(7'h01, 8'h03);
    wr(7'h00, 8'h03);
    wr(7'h10, 8'h00);
    wr(7'h11, 8'hFF);
    sb_push("presc_ps_seen", 1);
    sb_push("presc_len", 1024);
    sb_push("duty0_zero_hi", 0);
    sb_push("duty1_full_hi", 1024);
    wait_ps(3000, ok);
    sb_pop(ok);
    measure(-1, 7'h00, 8'h00, len, hi0, hi1, first0);
    sb_pop(len);
    sb_pop(hi0);
    sb_pop(hi1);

    wr(7'h01, 8'h00);
    sb_push("enable_off_pwm", 0);
    wr(7'h00, 8'h00);
    sb_pop(int'(pwm_out));
    sb_push("polarity_idle_pwm", 1);
    wr(7'h02, 8'h01);
    sb_pop(int'(pwm_out));

    sb_push("bad05_wr_err", 1);
    sb_push("bad05_pwm", 1);
    sb_push("bad05_wr_err_drop", 0);
    wr(7'h05, 8'hFF);
    sb_pop(int'(bus.wr_err));
    sb_pop(int'(pwm_out));
    @(negedge clk);
    sb_pop(int'(bus.wr_err));
    sb_push("bad18_wr_err", 1);
    wr(7'h18, 8'hFF);
    sb_pop(int'(bus.wr_err));
    sb_push("duty7_wr_err", 0);
    wr(7'h17, 8'h00);
    sb_pop(int'(bus.wr_err));
    sb_push("bad03_wr_err", 1);
    sb_push("bad03_pwm", 1);
    wr(7'h03, 8'hFF);
    sb_pop(int'(bus.wr_err));
    sb_pop(int'(pwm_out));

    wr(7'h00, 8'h01);
    wr(7'h10, 8'h40);
    sb_push("inv_ps_seen", 1);
    sb_push("inv_len", 256);
    sb_push("inv_hi0", 192);
    sb_push("inv_first0", 0);
    wait_ps(600, ok);
    sb_pop(ok);
    measure(-1, 7'h00, 8'h00, len, hi0, hi1, first0);
    sb_pop(len);
    sb_pop(hi0);
    sb_pop(first0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_multi_channel.md
PWM_MULTI_CHANNEL -- requirements
Module: pwm_multi_channel

Interface
REQ-001 Parameter NUM_CH, default 8, number of PWM channels; legal range 1..DUTY_W.
REQ-002 Parameter DUTY_W, default 8, duty and period-counter width; legal range 4..16.
REQ-003 Parameter PRESC_W, default 8, prescaler width; legal range 1..DUTY_W.
REQ-004 Reset and clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-005 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  synchronous, active-high reset.
REQ-007 Port wr_en  input  1  register write strobe, one write per cycle.
REQ-008 Port wr_addr  input  7  register address.
REQ-009 Port wr_data  input  DUTY_W  write data; upper unused bits ignored.
REQ-010 Port wr_err  output  1  one-cycle pulse when wr_en targets an unmapped address.
REQ-011 Port pwm_out  output  NUM_CH  registered PWM outputs.
REQ-012 Port period_start  output  1  one-cycle pulse on the cycle the period counter wraps to 0.

Function
REQ-013 Register map SHALL be: 0x00 enable mask [NUM_CH-1:0]; 0x01 prescaler [PRESC_W-1:0]; 0x02 polarity mask [NUM_CH-1:0]; 0x10+i duty shadow for channel i, i < NUM_CH.
REQ-014 Any other address with wr_en SHALL pulse wr_err on the next cycle and change no state.
REQ-015 Prescaler counter SHALL count 0..presc, assert tick on the cycle it equals presc, then reload 0; presc = 0 gives tick every cycle.
REQ-016 Period counter (DUTY_W bits) SHALL increment on tick and wrap from all-ones to 0; period = 2^DUTY_W ticks.
REQ-017 A prescaler write SHALL reset the prescaler counter to 0 on the same edge; the period counter is unaffected.
REQ-018 Duty writes SHALL update the shadow only; every active duty SHALL load from its shadow on the tick where the period counter wraps (glitch-free update).
REQ-019 Raw channel level SHALL be high when active duty is all-ones, else when period counter < active duty; duty 0 gives constant low.
REQ-020 pwm_out[i] SHALL be registered: raw level XOR polarity[i] when enable[i] = 1, else polarity[i] (idle level).
REQ-021 Enable and polarity writes SHALL take effect on pwm_out on the cycle after the write edge, not deferred to period wrap.
REQ-022 period_start SHALL pulse for exactly one clk cycle per wrap, aligned with the first pwm_out cycle of the new period.
REQ-023 A write to a duty shadow on the same edge as a wrap SHALL be lost for that period (active loads old shadow); the new value loads at the following wrap.

Reset
REQ-024 While rst = 1: enable, polarity, prescaler, all duty shadows, all active duties, prescaler counter, period counter = 0; pwm_out = 0; wr_err = 0; period_start = 0.
REQ-025 rst asserted mid-period SHALL abort the period immediately; wr_en is ignored while rst = 1.
REQ-026 The first tick after rst deasserts SHALL occur presc+1 = 1 cycles later with the period counter starting from 0.

Structure
REQ-027 Package pwm_pkg SHALL hold the register address constants (ADDR_ENABLE, ADDR_PRESC, ADDR_POLARITY, ADDR_DUTY_BASE) and the wr_addr width constant.
REQ-028 Per-channel compare, shadow/active duty and output register SHALL live in sub-module pwm_channel, instantiated NUM_CH times by generate; prescaler, period counter and register decode stay in the top.

Verification
REQ-029 Reset: hold rst 3 cycles after arbitrary writes -> pwm_out = 0, all registers read back via behaviour as 0, no period_start.
REQ-030 Basic duty: presc = 0, enable = 0x01, duty0 = 0x40 -> after next wrap, pwm_out[0] high 64 cycles, low 192 cycles per 256-cycle period; period_start every 256 cycles.
REQ-031 Extremes and prescale: duty0 = 0x00 and duty1 = 0xFF, presc = 3, enable = 0x03 -> pwm_out[0] constant 0, pwm_out[1] constant 1, period_start every 1024 cycles.
REQ-032 Glitch-free update: change duty0 0x40 -> 0x80 mid-period -> current period keeps 64 high cycles, next period shows 128.
REQ-033 Polarity/enable: polarity = 0x01 with enable = 0x00 -> pwm_out[0] = 1 next cycle; then enable = 0x01, duty0 = 0x40 -> 64 low, 192 high per period.
REQ-034 Bad address: wr_en with wr_addr = 0x05 -> wr_err pulses exactly one cycle, outputs unchanged.
